// File: rtl/nf_seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver:
// glyph table, segment bit positions and panel polarity encoding.
package nf_seven_seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic CC = 1'b0;
   localparam logic CA = 1'b1;

   // Entry n is the active-high {g,f,e,d,c,b,a} pattern for nibble n (F first).
   localparam logic [15:0][6:0] GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/nf_hex2seg.sv
// Nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module nf_hex2seg
   import nf_seven_seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = GLYPH[hex];

endmodule

// File: rtl/nf_seven_seg_dynamic.sv
// Time-multiplexed seven-segment driver: scans hn digits with a programmable
// slot length, PWM brightness, leading-zero blanking and CC/CA polarity.
module nf_seven_seg_dynamic
   import nf_seven_seg_pkg::*;
#(
   parameter int hn    = 4,
   parameter int div_w = 16,
   parameter int bri_w = 4
)(
   input  logic                clk,
   input  logic                resetn,
   input  logic [4*hn-1:0]     hex,
   input  logic [hn-1:0]       dot,
   input  logic                blank_lz,
   input  logic [bri_w-1:0]    bri,
   input  logic [div_w-1:0]    div,
   input  logic                cc_ca,
   output logic [7:0]          seg,
   output logic [hn-1:0]       dig,
   output logic                frame
);

   localparam int IDX_W = (hn > 1) ? $clog2(hn) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(hn - 1);

   logic [div_w-1:0] pre_q, pre_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [bri_w-1:0] pwm_q, pwm_d;
   logic [4*hn-1:0]  hex_q, hex_d;
   logic [hn-1:0]    dot_q, dot_d;
   logic [7:0]       seg_r_q, seg_r_d;
   logic [hn-1:0]    dig_r_q, dig_r_d;
   logic             frame_q, frame_d;

   logic             tick;
   logic             wrap;
   logic             pwm_en;
   logic [hn-1:0]    lz;
   logic             lz_run;
   logic [3:0]       nib;
   logic             dp;
   logic             blank;
   logic [6:0]       glyph;

   // lz[i] is set when snapshot nibbles i..hn-1 are all zero.
   always_comb begin
      lz     = '0;
      lz_run = 1'b1;
      for (int i = hn - 1; i >= 0; i--) begin
         lz_run = lz_run && (hex_q[4*i +: 4] == 4'h0);
         lz[i]  = lz_run;
      end
   end

   always_comb begin
      tick  = (pre_q >= div);
      pre_d = tick ? '0 : pre_q + 1'b1;
      wrap  = tick && (idx_q == IDX_LAST);
      idx_d = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
      end
      hex_d  = wrap ? hex : hex_q;
      dot_d  = wrap ? dot : dot_q;
      pwm_d  = pwm_q + 1'b1;
      pwm_en = (pwm_q < bri);
      // Digit 0 of a new frame decodes the incoming value being captured now.
      nib    = wrap ? hex[3:0] : hex_q[4*idx_d +: 4];
      dp     = wrap ? dot[0]   : dot_q[idx_d];
      blank  = blank_lz && (idx_d != '0) && lz[idx_d];
      frame_d = wrap;
   end

   nf_hex2seg u_hex2seg (
      .hex (nib),
      .seg (glyph)
   );

   always_comb begin
      seg_r_d = '0;
      dig_r_d = '0;
      if (pwm_en) begin
         seg_r_d[SEG_G:SEG_A] = blank ? 7'h00 : glyph;
         seg_r_d[SEG_DP]      = dp;
         dig_r_d[idx_d]       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre_q   <= '0;
         idx_q   <= '0;
         pwm_q   <= '0;
         hex_q   <= '0;
         dot_q   <= '0;
         seg_r_q <= '0;
         dig_r_q <= '0;
         frame_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         pwm_q   <= pwm_d;
         hex_q   <= hex_d;
         dot_q   <= dot_d;
         seg_r_q <= seg_r_d;
         dig_r_q <= dig_r_d;
         frame_q <= frame_d;
      end
   end

   assign seg   = seg_r_q ^ {8{cc_ca}};
   assign dig   = dig_r_q ^ {hn{cc_ca}};
   assign frame = frame_q;

endmodule

// File: tb/tb_nf_seven_seg_dynamic.sv
// Scoreboard bench for nf_seven_seg_dynamic (hn=4): a cycle model pushes the
// expected registered outputs at each posedge; they are popped at the negedge.
module tb_nf_seven_seg_dynamic;

   localparam int HN    = 4;
   localparam int DIVW  = 16;
   localparam int BRIW  = 4;

   logic            clk = 1'b0;
   logic            resetn = 1'b1;
   logic [4*HN-1:0] hex = '0;
   logic [HN-1:0]   dot = '0;
   logic            blank_lz = 1'b0;
   logic [BRIW-1:0] bri = '0;
   logic [DIVW-1:0] div = '0;
   logic            cc_ca = 1'b0;
   logic [7:0]      seg;
   logic [HN-1:0]   dig;
   logic            frame;

   nf_seven_seg_dynamic #(.hn(HN), .div_w(DIVW), .bri_w(BRIW)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .hex      (hex),
      .dot      (dot),
      .blank_lz (blank_lz),
      .bri      (bri),
      .div      (div),
      .cc_ca    (cc_ca),
      .seg      (seg),
      .dig      (dig),
      .frame    (frame)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]    s;
      logic [HN-1:0] d;
      logic          f;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_push;
   exp_t e_pop;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @%0t: got %02h expected %02h", tag, $time, got, want);
      end
   endtask

   // Standard glyphs 0-9, A, b, C, d, E, F as {g,f,e,d,c,b,a}.
   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   // Reference model state
   int              m_pre, m_idx, m_pwm;
   logic [4*HN-1:0] m_hex;
   logic [HN-1:0]   m_dot;
   logic            m_tick, m_wrap, m_en, m_blank;
   logic [3:0]      m_nib;

   always @(posedge clk) begin
      e_push = '0;
      if (!resetn) begin
         m_pre = 0; m_idx = 0; m_pwm = 0; m_hex = '0; m_dot = '0;
      end else begin
         m_tick = (m_pre >= int'(div));
         m_wrap = m_tick && (m_idx == HN - 1);
         m_pre  = m_tick ? 0 : m_pre + 1;
         if (m_tick) m_idx = m_wrap ? 0 : m_idx + 1;
         if (m_wrap) begin
            m_hex = hex;
            m_dot = dot;
         end
         m_en  = (m_pwm < int'(bri));
         m_pwm = (m_pwm + 1) % (1 << BRIW);
         m_nib = m_hex[4*m_idx +: 4];
         m_blank = blank_lz && (m_idx > 0) && ((m_hex >> (4*m_idx)) == '0);
         if (m_en) begin
            e_push.s = {m_dot[m_idx], m_blank ? 7'h00 : ref_glyph(m_nib)};
            e_push.d = HN'(1 << m_idx);
         end
         e_push.f = m_wrap;
      end
      exp_q.push_back(e_push);
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_pop = exp_q.pop_front();
         check_eq("seg", seg, e_pop.s ^ {8{cc_ca}});
         check_eq("dig", 8'(dig), 8'(e_pop.d ^ {HN{cc_ca}}));
         check_eq("frame", 8'(frame), 8'(e_pop.f));
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
      #2;
   endtask

   task automatic count_active(input int n, output int act);
      act = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         if (dig !== {HN{cc_ca}}) act++;
      end
      #1;
   endtask

   int act;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Common-anode reset: everything inactive (all ones).
      cc_ca = 1'b1; bri = 4'hF; div = 16'd3; hex = 16'h2019;
      #1 resetn = 1'b0;
      step(3);
      check_eq("rst_ca_seg", seg, 8'hFF);
      check_eq("rst_ca_dig", 8'(dig), 8'h0F);
      resetn = 1'b1;
      step(40);
      cc_ca = 1'b0;
      step(40);

      // Leading-zero blanking, then a decimal point on a blanked digit.
      hex = 16'h0007; blank_lz = 1'b1;
      step(40);
      dot = 4'b0100;
      step(40);

      // Mid-frame value changes with assorted slot lengths and polarities.
      for (int k = 0; k < 12; k++) begin
         hex      = 16'($urandom);
         dot      = 4'($urandom);
         blank_lz = 1'($urandom);
         div      = 16'($urandom_range(0, 5));
         cc_ca    = 1'($urandom);
         step($urandom_range(3, 30));
      end
      hex = 16'h00A0; blank_lz = 1'b1; dot = '0; div = 16'd0;
      step(20);

      // Brightness: dark, then half duty.
      cc_ca = 1'b0; div = 16'd3; bri = 4'd0;
      step(2);
      count_active(32, act);
      check_eq("bri0_active", 8'(act), 8'd0);
      bri = 4'd8;
      step(2);
      count_active(32, act);
      check_eq("bri8_active", 8'(act), 8'd16);
      cc_ca = 1'b1;
      step(2);
      count_active(32, act);
      check_eq("bri8_active_ca", 8'(act), 8'd16);

      // Long slots, lowering div mid-count, then asynchronous reset mid-slot.
      bri = 4'hF; hex = 16'h2019; blank_lz = 1'b0; div = 16'd100;
      step(150);
      div = 16'd2;
      step(30);
      div = 16'd100;
      step(150);
      resetn = 1'b0;
      #1;
      check_eq("async_rst_seg", seg, 8'hFF);
      check_eq("async_rst_dig", 8'(dig), 8'h0F);
      check_eq("async_rst_frame", 8'(frame), 8'h00);
      step(3);
      resetn = 1'b1;
      step(250);
      cc_ca = 1'b0;
      step(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
